ddr_cmd_decoder: RTL and testbench



---
 rtl/ddr_cmd_pkg.sv | 35 +++
 rtl/ddr_cmd_decoder_bank_table.sv | 37 +++
 rtl/ddr_cmd_decoder.sv | 200 ++++++++++++++++++++
 tb/tb_ddr_cmd_decoder.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/ddr_cmd_pkg.sv
// Shared types and constants for the DDR command decoder and its bank table.
package ddr_cmd_pkg;

    localparam int ROWS  = 131072;
    localparam int COLS  = 1024;
    localparam int BANKS = 16;
    localparam int RW    = $clog2(ROWS);
    localparam int CW    = $clog2(COLS);
    localparam int BW    = $clog2(BANKS);

    typedef enum logic [1:0] {
        ACTIVE  = 2'd0,
        PWRDN   = 2'd1,
        SELFREF = 2'd2
    } pstate_t;

    // Bit positions of the strobes inside the registered strobe vector
    typedef enum logic [4:0] {
        C_ACT, C_BST, C_CFG, C_CKEH, C_CKEL, C_DPD, C_DPDX, C_MRR, C_MRW, C_PD,
        C_PDX, C_PR, C_PRA, C_RD, C_RDA, C_REF, C_SRF, C_WR, C_WRA
    } cmd_t;

    localparam int NCMD = 19;

    localparam logic [2:0] OP_MRS = 3'b000;
    localparam logic [2:0] OP_REF = 3'b001;
    localparam logic [2:0] OP_PRE = 3'b010;
    localparam logic [2:0] OP_WR  = 3'b100;
    localparam logic [2:0] OP_RD  = 3'b101;
    localparam logic [2:0] OP_ZQ  = 3'b110;
    localparam logic [2:0] OP_NOP = 3'b111;

    localparam logic [BW-1:0] MPR_MR = 4'd3;

endpackage

// File: rtl/ddr_cmd_decoder_bank_table.sv
// Per-bank open flags and open rows; updates land at the clock edge so the
// next command already sees them.
module ddr_bank_table
    import ddr_cmd_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          do_open,
    input  logic          do_close,
    input  logic          close_all,
    input  logic [BW-1:0] bank,
    input  logic [RW-1:0] new_row,
    output logic          is_open,
    output logic          any_open,
    output logic [RW-1:0] open_row
);

    logic [BANKS-1:0] open_q;
    logic [RW-1:0]    row_q [BANKS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            open_q <= '0;
            for (int i = 0; i < BANKS; i++) row_q[i] <= '0;
        end else begin
            if (close_all)     open_q       <= '0;
            else if (do_open)  open_q[bank] <= 1'b1;
            else if (do_close) open_q[bank] <= 1'b0;
            if (do_open) row_q[bank] <= new_row;
        end
    end

    assign is_open  = open_q[bank];
    assign any_open = |open_q;
    assign open_row = row_q[bank];

endmodule

// File: rtl/ddr_cmd_decoder.sv
// DDR4-style command decoder: registered command strobes, bank tracking,
// CKE power state and MPR mode, with sticky illegal-command flag.
//   state   | meaning
//   ACTIVE  | CKE high, commands decoded
//   PWRDN   | power-down after CKE fall with NOP/illegal command
//   SELFREF | self-refresh after CKE fall with REF, all banks closed
module ddr_cmd_decoder
    import ddr_cmd_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          halt,
    input  logic          cs_n,
    input  logic          act_n,
    input  logic          ras_n,
    input  logic          cas_n,
    input  logic          we_n,
    input  logic          cke,
    input  logic [1:0]    bg,
    input  logic [1:0]    ba,
    input  logic [13:0]   addr,
    output logic          ACT,
    output logic          BST,
    output logic          CFG,
    output logic          CKEH,
    output logic          CKEL,
    output logic          DPD,
    output logic          DPDX,
    output logic          MRR,
    output logic          MRW,
    output logic          PD,
    output logic          PDX,
    output logic          PR,
    output logic          PRA,
    output logic          RD,
    output logic          RDA,
    output logic          REF,
    output logic          SRF,
    output logic          WR,
    output logic          WRA,
    output logic [BW-1:0] bank,
    output logic [RW-1:0] row,
    output logic [CW-1:0] column,
    output logic          cmd_err,
    output logic [1:0]    pstate
);

    pstate_t         ps_q, ps_d;
    logic            cke_prev;
    logic            mpr_q, mpr_d;
    logic            err_q, err_d;
    logic [NCMD-1:0] strb_q, strb_d;
    logic            tbl_open, tbl_close, tbl_close_all;
    logic            tbl_is_open, tbl_any_open;
    logic [RW-1:0]   tbl_row;
    logic [BW-1:0]   bank_in;
    logic [2:0]      opc;
    logic            is_nop;

    assign bank_in = {bg, ba};
    assign opc     = {ras_n, cas_n, we_n};
    assign is_nop  = cs_n | (act_n & (opc == OP_NOP));

    ddr_bank_table u_tbl (
        .clk       (clk),
        .rst       (rst),
        .do_open   (tbl_open),
        .do_close  (tbl_close),
        .close_all (tbl_close_all),
        .bank      (bank_in),
        .new_row   ({opc, addr}),
        .is_open   (tbl_is_open),
        .any_open  (tbl_any_open),
        .open_row  (tbl_row)
    );

    always_comb begin
        strb_d        = '0;
        ps_d          = ps_q;
        mpr_d         = mpr_q;
        err_d         = err_q;
        tbl_open      = 1'b0;
        tbl_close     = 1'b0;
        tbl_close_all = 1'b0;
        if (!halt) begin
            case ({cke_prev, cke})
                2'b11: if (!cs_n) begin
                    if (!act_n) begin
                        if (tbl_is_open) err_d = 1'b1;
                        else begin
                            strb_d[C_ACT] = 1'b1;
                            tbl_open      = 1'b1;
                        end
                    end else begin
                        case (opc)
                            OP_MRS: if (tbl_any_open) err_d = 1'b1;
                            else begin
                                strb_d[C_MRW] = 1'b1;
                                if (bank_in == MPR_MR) mpr_d = addr[2];
                            end
                            OP_REF: if (tbl_any_open) err_d = 1'b1;
                                    else strb_d[C_REF] = 1'b1;
                            OP_PRE: if (addr[10]) begin
                                strb_d[C_PRA] = 1'b1;
                                tbl_close_all = 1'b1;
                            end else begin
                                strb_d[C_PR]  = 1'b1;
                                tbl_close     = 1'b1;
                            end
                            OP_WR: if (!tbl_is_open) err_d = 1'b1;
                            else begin
                                if (addr[10]) strb_d[C_WRA] = 1'b1;
                                else          strb_d[C_WR]  = 1'b1;
                                strb_d[C_BST] = ~addr[12];
                                tbl_close     = addr[10];
                            end
                            // In MPR mode reads become MRR and leave the bank open
                            OP_RD: if (!tbl_is_open) err_d = 1'b1;
                            else if (mpr_q) strb_d[C_MRR] = 1'b1;
                            else begin
                                if (addr[10]) strb_d[C_RDA] = 1'b1;
                                else          strb_d[C_RD]  = 1'b1;
                                strb_d[C_BST] = ~addr[12];
                                tbl_close     = addr[10];
                            end
                            OP_ZQ:  strb_d[C_CFG] = 1'b1;
                            OP_NOP: ;
                            default: err_d = 1'b1;
                        endcase
                    end
                end
                2'b10: begin
                    strb_d[C_CKEL] = 1'b1;
                    if (!cs_n && act_n && opc == OP_REF && !tbl_any_open) begin
                        strb_d[C_SRF] = 1'b1;
                        ps_d          = SELFREF;
                    end else begin
                        strb_d[C_PD] = 1'b1;
                        ps_d         = PWRDN;
                        if (!is_nop) err_d = 1'b1;
                    end
                end
                2'b01: begin
                    strb_d[C_CKEH] = 1'b1;
                    strb_d[C_PDX]  = (ps_q == PWRDN);
                    ps_d           = ACTIVE;
                    if (!is_nop) err_d = 1'b1;
                end
                default: if (!is_nop) err_d = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ps_q     <= ACTIVE;
            cke_prev <= 1'b1;
            mpr_q    <= 1'b0;
            err_q    <= 1'b0;
            strb_q   <= '0;
            bank     <= '0;
            row      <= '0;
            column   <= '0;
        end else begin
            strb_q <= strb_d;
            if (!halt) begin
                ps_q     <= ps_d;
                cke_prev <= cke;
                mpr_q    <= mpr_d;
                err_q    <= err_d;
                bank     <= bank_in;
                row      <= !act_n ? {opc, addr} : tbl_row;
                column   <= addr[CW-1:0];
            end
        end
    end

    assign ACT     = strb_q[C_ACT];
    assign BST     = strb_q[C_BST];
    assign CFG     = strb_q[C_CFG];
    assign CKEH    = strb_q[C_CKEH];
    assign CKEL    = strb_q[C_CKEL];
    assign DPD     = strb_q[C_DPD];
    assign DPDX    = strb_q[C_DPDX];
    assign MRR     = strb_q[C_MRR];
    assign MRW     = strb_q[C_MRW];
    assign PD      = strb_q[C_PD];
    assign PDX     = strb_q[C_PDX];
    assign PR      = strb_q[C_PR];
    assign PRA     = strb_q[C_PRA];
    assign RD      = strb_q[C_RD];
    assign RDA     = strb_q[C_RDA];
    assign REF     = strb_q[C_REF];
    assign SRF     = strb_q[C_SRF];
    assign WR      = strb_q[C_WR];
    assign WRA     = strb_q[C_WRA];
    assign cmd_err = err_q;
    assign pstate  = ps_q;

endmodule

// File: tb/tb_ddr_cmd_decoder.sv
// Scoreboard bench for ddr_cmd_decoder: directed commands push expectations,
// a monitor compares each cycle's registered outputs.
module tb_ddr_cmd_decoder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic halt = 1'b0, cs_n = 1'b1, act_n = 1'b1, ras_n = 1'b1, cas_n = 1'b1, we_n = 1'b1, cke = 1'b1;
    logic [1:0] bg = '0, ba = '0;
    logic [13:0] addr = '0;
    logic ACT, BST, CFG, CKEH, CKEL, DPD, DPDX, MRR, MRW, PD, PDX, PR, PRA, RD, RDA, REF, SRF, WR, WRA;
    logic [3:0] bank;
    logic [16:0] row;
    logic [9:0] column;
    logic cmd_err;
    logic [1:0] pstate;

    always #5 clk = ~clk;

    ddr_cmd_decoder dut (
        .clk(clk), .rst(rst), .halt(halt), .cs_n(cs_n), .act_n(act_n), .ras_n(ras_n),
        .cas_n(cas_n), .we_n(we_n), .cke(cke), .bg(bg), .ba(ba), .addr(addr),
        .ACT(ACT), .BST(BST), .CFG(CFG), .CKEH(CKEH), .CKEL(CKEL), .DPD(DPD), .DPDX(DPDX),
        .MRR(MRR), .MRW(MRW), .PD(PD), .PDX(PDX), .PR(PR), .PRA(PRA), .RD(RD), .RDA(RDA),
        .REF(REF), .SRF(SRF), .WR(WR), .WRA(WRA), .bank(bank), .row(row), .column(column),
        .cmd_err(cmd_err), .pstate(pstate)
    );

    localparam logic [18:0] S_ACT = 19'h1 << 18, S_BST = 19'h1 << 17, S_CFG = 19'h1 << 16,
        S_CKEH = 19'h1 << 15, S_CKEL = 19'h1 << 14, S_MRR = 19'h1 << 11, S_MRW = 19'h1 << 10,
        S_PD = 19'h1 << 9, S_PDX = 19'h1 << 8, S_PR = 19'h1 << 7, S_PRA = 19'h1 << 6,
        S_RD = 19'h1 << 5, S_REF = 19'h1 << 3, S_SRF = 19'h1 << 2, S_WRA = 19'h1;

    typedef struct {
        logic [18:0] strb;
        logic        err;
        logic [1:0]  ps;
        bit          chk;
        logic [3:0]  bank;
        logic [16:0] row;
        logic [9:0]  col;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int n_tests = 0;
    int n_fail  = 0;

    function automatic logic [18:0] strobes();
        return {ACT, BST, CFG, CKEH, CKEL, DPD, DPDX, MRR, MRW, PD, PDX, PR, PRA,
                RD, RDA, REF, SRF, WR, WRA};
    endfunction

    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            exp_t e;
            logic [21:0] got, want;
            e = exp_q.pop_front();
            got  = {strobes(), cmd_err, pstate};
            want = {e.strb, e.err, e.ps};
            n_tests++;
            if (got !== want || (e.chk && {bank, row, column} !== {e.bank, e.row, e.col})) begin
                n_fail++;
                $display("FAIL %s: got strb=%h err=%b ps=%0d bank=%0d row=%h col=%h, want strb=%h err=%b ps=%0d bank=%0d row=%h col=%h",
                         e.name, got[21:3], got[2], got[1:0], bank, row, column,
                         e.strb, e.err, e.ps, e.bank, e.row, e.col);
            end
        end
    end

    task automatic step(input logic ck, input logic h, input logic csn, input logic actn,
                        input logic [2:0] opc, input logic [3:0] bk, input logic [13:0] a,
                        input logic [18:0] es, input logic ee, input logic [1:0] eps,
                        input bit chk, input logic [3:0] eb, input logic [16:0] er,
                        input logic [9:0] ec, input string nm);
        exp_t e;
        @(negedge clk);
        cke = ck; halt = h; cs_n = csn; act_n = actn;
        {ras_n, cas_n, we_n} = opc; {bg, ba} = bk; addr = a;
        e.strb = es; e.err = ee; e.ps = eps; e.chk = chk;
        e.bank = eb; e.row = er; e.col = ec; e.name = nm;
        exp_q.push_back(e);
    endtask

    task automatic nop_step(input logic [18:0] es, input logic ee, input string nm);
        step(1'b1, 1'b0, 1'b1, 1'b1, 3'b111, 4'd0, 14'h0, es, ee, 2'd0, 1'b0, 4'd0, 17'h0, 10'h0, nm);
    endtask

    task automatic pulse_reset(input string nm);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        cs_n = 1'b1; cke = 1'b1; halt = 1'b0;
        #1;
        n_tests++;
        if ({strobes(), cmd_err, pstate, bank, row, column} !== '0) begin
            n_fail++;
            $display("FAIL %s: got strb=%h err=%b ps=%0d bank=%0d row=%h col=%h, want all zero",
                     nm, strobes(), cmd_err, pstate, bank, row, column);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        pulse_reset("reset_state");

        step(1, 0, 0, 0, 3'b000, 4'd5, 14'h0123, S_ACT, 0, 0, 1, 4'd5, 17'h00123, 10'h123, "act_b5");
        step(1, 0, 0, 1, 3'b101, 4'd5, 14'h100A, S_RD, 0, 0, 1, 4'd5, 17'h00123, 10'h00A, "rd_b5");
        step(1, 0, 0, 0, 3'b101, 4'd9, 14'h3FFF, S_ACT, 0, 0, 1, 4'd9, 17'h17FFF, 10'h3FF, "act_b9_maxrow");
        step(1, 0, 0, 1, 3'b101, 4'd2, 14'h100A, '0, 1, 0, 0, 0, 0, 0, "rd_closed_b2");
        nop_step('0, 1, "err_sticky");
        pulse_reset("reset_midstream");
        step(1, 0, 0, 1, 3'b101, 4'd5, 14'h1000, '0, 1, 0, 0, 0, 0, 0, "rd_after_reset");

        pulse_reset("reset2");
        step(1, 0, 0, 0, 3'b000, 4'd5, 14'h0000, S_ACT, 0, 0, 0, 0, 0, 0, "act_b5_r0");
        step(1, 0, 0, 1, 3'b100, 4'd5, 14'h0400, S_WRA | S_BST, 0, 0, 1, 4'd5, 17'h0, 10'h0, "wra_bc4");
        step(1, 0, 0, 1, 3'b101, 4'd5, 14'h1000, '0, 1, 0, 0, 0, 0, 0, "rd_after_wra");

        pulse_reset("reset3");
        step(1, 0, 0, 1, 3'b000, 4'd3, 14'h0004, S_MRW, 0, 0, 0, 0, 0, 0, "mrw_mpr_on");
        step(1, 0, 0, 0, 3'b000, 4'd0, 14'h0055, S_ACT, 0, 0, 0, 0, 0, 0, "act_b0");
        step(1, 0, 0, 1, 3'b101, 4'd0, 14'h1000, S_MRR, 0, 0, 1, 4'd0, 17'h00055, 10'h0, "rd_mpr_mrr");
        step(1, 0, 0, 1, 3'b010, 4'd0, 14'h0000, S_PR, 0, 0, 0, 0, 0, 0, "pr_b0");
        step(1, 0, 0, 1, 3'b000, 4'd3, 14'h0000, S_MRW, 0, 0, 0, 0, 0, 0, "mrw_mpr_off");
        step(1, 0, 0, 0, 3'b000, 4'd0, 14'h0066, S_ACT, 0, 0, 0, 0, 0, 0, "act_b0_again");
        step(1, 0, 0, 1, 3'b101, 4'd0, 14'h1000, S_RD, 0, 0, 1, 4'd0, 17'h00066, 10'h0, "rd_normal");
        step(1, 0, 0, 0, 3'b000, 4'd0, 14'h0077, '0, 1, 0, 0, 0, 0, 0, "act_open_bank");

        pulse_reset("reset4");
        step(1, 0, 0, 1, 3'b010, 4'd0, 14'h0400, S_PRA, 0, 0, 0, 0, 0, 0, "pra");
        step(0, 0, 0, 1, 3'b001, 4'd0, 14'h0000, S_SRF | S_CKEL, 0, 2, 0, 0, 0, 0, "srf_entry");
        step(0, 0, 1, 1, 3'b111, 4'd0, 14'h0000, '0, 0, 2, 0, 0, 0, 0, "selfref_hold");
        step(1, 0, 1, 1, 3'b111, 4'd0, 14'h0000, S_CKEH, 0, 0, 0, 0, 0, 0, "srf_exit");
        step(0, 0, 1, 1, 3'b111, 4'd0, 14'h0000, S_PD | S_CKEL, 0, 1, 0, 0, 0, 0, "pd_entry");
        step(1, 0, 1, 1, 3'b111, 4'd0, 14'h0000, S_PDX | S_CKEH, 0, 0, 0, 0, 0, 0, "pd_exit");
        step(1, 0, 0, 1, 3'b110, 4'd0, 14'h0000, S_CFG, 0, 0, 0, 0, 0, 0, "zq_cfg");
        step(1, 0, 0, 1, 3'b011, 4'd0, 14'h0000, '0, 1, 0, 0, 0, 0, 0, "opcode_011");
        step(0, 0, 0, 0, 3'b000, 4'd1, 14'h0000, S_PD | S_CKEL, 1, 1, 0, 0, 0, 0, "cke_fall_act");
        step(1, 0, 1, 1, 3'b111, 4'd0, 14'h0000, S_PDX | S_CKEH, 1, 0, 0, 0, 0, 0, "pd_exit2");

        pulse_reset("reset5");
        for (int i = 0; i < 3; i++)
            step(1, 1, 0, 0, 3'b000, 4'd7, 14'h0042, '0, 0, 0, 1, 4'd0, 17'h0, 10'h0, "halt_act");
        step(1, 0, 0, 1, 3'b101, 4'd7, 14'h1000, '0, 1, 0, 0, 0, 0, 0, "rd_after_halt");

        repeat (3) @(negedge clk);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
